jtag_tgt_sequencer: RTL

- Internal JTAG master that drives the RISC-V target TAP from the system clock, so the bootloader can reset the TAP and shift IR/DR without an external probe.
- Arbitrates the target pins (TGT_*) between this engine and the debug bridge's TGT_* outputs. The external debugger has priority once the engine is idle.
- Always parks the target TAP in Run-Test/Idle (RTI) between commands.

---
 rtl/jtag_tgt_sequencer_if.sv | 29 ++
 rtl/jtag_tgt_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tgt_sequencer_if.sv
// ============================================================================
// Module   : jtag_tgt_sequencer_if
// Brief    : Command/response bundle between a host and the JTAG sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jtag_tgt_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/jtag_tgt_sequencer.sv
// ============================================================================
// Module   : jtag_tgt_sequencer
// Brief    : Internal JTAG master for the target TAP with external-debugger
//            pin arbitration; parks the TAP in Run-Test/Idle between commands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tgt_sequencer #(
  parameter int CLK_DIV        = 4,
  parameter bit AUTO_TAP_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  jtag_tgt_sequencer_if.slave   cmd,
  input  logic                  ext_req,
  output logic                  ext_gnt,
  input  logic                  dbg_tck,
  input  logic                  dbg_tms,
  input  logic                  dbg_tdi,
  input  logic                  dbg_trst,
  output logic                  dbg_tdo,
  output logic                  tgt_tck,
  output logic                  tgt_tms,
  output logic                  tgt_tdi,
  output logic                  tgt_trst,
  input  logic                  tgt_tdo
);

  localparam int c_div_w = $clog2(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  localparam logic [1:0] c_op_reset = 2'b00;
  localparam logic [1:0] c_op_idle  = 2'b01;
  localparam logic [1:0] c_op_ir    = 2'b10;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_PRE   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_POST  = 3'd4,
    ST_RSP   = 3'd5,
    ST_EXT   = 3'd6
  } state_t;

  localparam state_t c_start_state = AUTO_TAP_RESET ? ST_INIT : ST_IDLE;

  state_t              r_state;
  logic [c_div_w-1:0]  r_div;
  logic [5:0]          r_cnt;
  logic                r_tck;
  logic                r_tms;
  logic                r_tdi;
  logic [1:0]          r_op;
  logic [5:0]          r_len;
  logic [31:0]         r_data;
  logic [31:0]         r_cap;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_data;
  logic                r_busy;
  logic                r_ext_gnt;
  logic                r_ext_s1;
  logic                r_ext_s2;

  state_t              w_nxt_state;
  logic [5:0]          w_nxt_cnt;
  logic [5:0]          w_eff_len;
  state_t              w_first_state;
  logic                w_handshake;

  function automatic logic [5:0] pre_len(input logic [1:0] op);
    case (op)
      c_op_reset: return 6'd6;
      c_op_ir:    return 6'd4;
      default:    return 6'd3;
    endcase
  endfunction

  // TMS for TCK number cnt of a given phase; every sequence ends with TMS=0 so the TAP rests in RTI.
  function automatic logic tms_at(input state_t st, input logic [1:0] op,
                                  input logic [5:0] len, input logic [5:0] cnt);
    case (st)
      ST_INIT:  return cnt != 6'd5;
      ST_PRE: begin
        case (op)
          c_op_reset: return cnt != 6'd5;
          c_op_ir:    return cnt < 6'd2;
          default:    return cnt == 6'd0;
        endcase
      end
      ST_SHIFT: return (op != c_op_idle) && (cnt == len - 6'd1);
      ST_POST:  return cnt == 6'd0;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic tdi_at(input state_t st, input logic [1:0] op,
                                  input logic [31:0] data, input logic [5:0] cnt);
    logic [31:0] sh;
    sh = data >> cnt;
    return (st == ST_SHIFT) && (op != c_op_idle) && sh[0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
    end else begin
      r_ext_s1 <= ext_req;
      r_ext_s2 <= r_ext_s1;
    end
  end

  assign w_eff_len     = (cmd.cmd_len == 6'd0) ? 6'd1 :
                         (cmd.cmd_len > 6'd32) ? 6'd32 : cmd.cmd_len;
  assign w_first_state = (cmd.cmd_op == c_op_idle) ? ST_SHIFT : ST_PRE;
  assign w_handshake   = cmd.cmd_valid && r_cmd_ready;

  // Position of the following TCK within the command's phase sequence.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 6'd1;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == 6'd5) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = 6'd0;
        end
      end
      ST_PRE: begin
        if (r_cnt == pre_len(r_op) - 6'd1) begin
          w_nxt_state = (r_op == c_op_reset) ? ST_RSP : ST_SHIFT;
          w_nxt_cnt   = 6'd0;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == r_len - 6'd1) begin
          w_nxt_state = (r_op == c_op_idle) ? ST_RSP : ST_POST;
          w_nxt_cnt   = 6'd0;
        end
      end
      ST_POST: begin
        if (r_cnt == 6'd1) begin
          w_nxt_state = ST_RSP;
          w_nxt_cnt   = 6'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_start_state;
      r_div       <= '0;
      r_cnt       <= 6'd0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_op        <= 2'b00;
      r_len       <= 6'd1;
      r_data      <= 32'd0;
      r_cap       <= 32'd0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_busy      <= AUTO_TAP_RESET;
      r_ext_gnt   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_INIT, ST_PRE, ST_SHIFT, ST_POST: begin
          if (r_div != c_div_last) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_tck) begin
              r_tck <= 1'b1;
              if (r_state == ST_SHIFT && r_op != c_op_idle)
                r_cap <= r_cap | (32'(tgt_tdo) << r_cnt);
            end else begin
              r_tck   <= 1'b0;
              r_state <= w_nxt_state;
              r_cnt   <= w_nxt_cnt;
              r_tms   <= tms_at(w_nxt_state, r_op, r_len, w_nxt_cnt);
              r_tdi   <= tdi_at(w_nxt_state, r_op, r_data, w_nxt_cnt);
              if (w_nxt_state == ST_IDLE)
                r_busy <= 1'b0;
            end
          end
        end
        ST_RSP: begin
          // Hold TCK low for one more half-period before reporting completion.
          if (r_div != c_div_last) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_cap;
            r_state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_handshake) begin
            r_op        <= cmd.cmd_op;
            r_len       <= w_eff_len;
            r_data      <= cmd.cmd_data;
            r_cap       <= 32'd0;
            r_cnt       <= 6'd0;
            r_div       <= '0;
            r_state     <= w_first_state;
            r_tms       <= tms_at(w_first_state, cmd.cmd_op, w_eff_len, 6'd0);
            r_tdi       <= tdi_at(w_first_state, cmd.cmd_op, cmd.cmd_data, 6'd0);
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
          end else if (r_ext_s2) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            if (!r_cmd_ready) begin
              r_ext_gnt <= 1'b1;
              r_state   <= ST_EXT;
            end
          end else begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        ST_EXT: begin
          if (!r_ext_s2) begin
            r_ext_gnt <= 1'b0;
            r_cnt     <= 6'd0;
            r_div     <= '0;
            r_tck     <= 1'b0;
            r_tdi     <= 1'b0;
            if (AUTO_TAP_RESET) begin
              // Debugger may have left the TAP anywhere; walk it back to RTI.
              r_state <= ST_INIT;
              r_tms   <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_tms   <= 1'b0;
            end
          end
        end
        default: r_state <= c_start_state;
      endcase
    end
  end

  assign tgt_tck  = r_ext_gnt ? dbg_tck : r_tck;
  assign tgt_tms  = r_ext_gnt ? dbg_tms : r_tms;
  assign tgt_tdi  = r_ext_gnt ? dbg_tdi : r_tdi;
  assign tgt_trst = r_ext_gnt & dbg_trst;
  assign dbg_tdo  = r_ext_gnt & tgt_tdo;
  assign ext_gnt  = r_ext_gnt;

  assign cmd.cmd_ready = r_cmd_ready;
  assign cmd.rsp_valid = r_rsp_valid;
  assign cmd.rsp_data  = r_rsp_data;
  assign cmd.busy      = r_busy;

endmodule

`default_nettype wire
